// File: rtl/fetch_inst_queue_pkg.sv
// Shared definitions for the fetch instruction queue: entry layout, fault bits,
// FSM encoding and the privileged opcodes that fault in user mode.
package fetch_inst_queue_pkg;

    localparam int unsigned ENTRY_W  = 68;
    localparam int unsigned OPCODE_W = 10;

    // Bit positions inside the 3-bit fault field of an entry
    localparam int unsigned FAULT_BIT_INVALID   = 0;
    localparam int unsigned FAULT_BIT_PRIVILEGE = 1;
    localparam int unsigned FAULT_BIT_PAGEFAULT = 2;

    // Privileged opcodes, matched against inst[30:21]
    localparam logic [OPCODE_W-1:0] FAULT_INSTRUCTION_SRTISR  = 10'h0a1;
    localparam logic [OPCODE_W-1:0] FAULT_INSTRUCTION_SRKPDTR = 10'h0a2;
    localparam logic [OPCODE_W-1:0] FAULT_INSTRUCTION_SRIEIW  = 10'h0a3;
    localparam logic [OPCODE_W-1:0] FAULT_INSTRUCTION_SRTISW  = 10'h0a4;
    localparam logic [OPCODE_W-1:0] FAULT_INSTRUCTION_SRKPDTW = 10'h0a5;
    localparam logic [OPCODE_W-1:0] FAULT_INSTRUCTION_SRMMUW  = 10'h0a6;
    localparam logic [OPCODE_W-1:0] FAULT_INSTRUCTION_HALT    = 10'h131;
    localparam logic [OPCODE_W-1:0] FAULT_INSTRUCTION_IDTS    = 10'h132;

    typedef struct packed {
        logic [2:0]  fault;
        logic        kernel;
        logic [31:0] inst;
        logic [31:0] pc;
    } queueEntry_t;

    typedef enum logic {
        STATE_RUN   = 1'b0,
        STATE_FENCE = 1'b1
    } queueState_t;

endpackage

// File: rtl/fetch_inst_queue_ram.sv
// Entry storage: synchronous write, asynchronous read at the head pointer.
module fetch_inst_queue_ram
    import fetch_inst_queue_pkg::*;
#(
    parameter int unsigned P_DEPTH   = 32,
    parameter int unsigned P_DEPTH_N = 5
) (
    input  logic                 iCLOCK,
    input  logic                 iWR_ENA,
    input  logic [P_DEPTH_N-1:0] iWR_ADDR,
    input  queueEntry_t          iWR_DATA,
    input  logic [P_DEPTH_N-1:0] iRD_ADDR,
    output queueEntry_t          oRD_DATA
);

    queueEntry_t mem [P_DEPTH];

    always_ff @(posedge iCLOCK) begin
        if (iWR_ENA) begin
            mem[iWR_ADDR] <= iWR_DATA;
        end
    end

    assign oRD_DATA = mem[iRD_ADDR];

endmodule

// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue: fault classification on entry, RAM plus
// a registered output stage with bypass, and a fetch fence after faults.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
#(
    parameter int unsigned P_DEPTH       = 32,
    parameter int unsigned P_DEPTH_N     = 5,
    parameter int unsigned P_STOP_TH     = 27,
    parameter int unsigned P_FAULT_FENCE = 1
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iFREE_REFRESH,
    input  logic                 iPREVIOUS_INST_VALID,
    input  logic                 iPREVIOUS_PAGEFAULT,
    input  logic [13:0]          iPREVIOUS_MMU_FLAGS,
    input  logic                 iPREVIOUS_PAGING_ENA,
    input  logic                 iPREVIOUS_KERNEL_ACCESS,
    input  logic [31:0]          iPREVIOUS_INST,
    input  logic [31:0]          iPREVIOUS_PC,
    output logic                 oPREVIOUS_FETCH_STOP,
    output logic                 oPREVIOUS_LOCK,
    output logic                 oNEXT_INST_VALID,
    output logic                 oNEXT_FAULT_PAGEFAULT,
    output logic                 oNEXT_FAULT_PRIVILEGE_ERROR,
    output logic                 oNEXT_FAULT_INVALID_INST,
    output logic [31:0]          oNEXT_INST,
    output logic [31:0]          oNEXT_PC,
    output logic                 oNEXT_KERNEL,
    input  logic                 iNEXT_LOCK,
    output logic [P_DEPTH_N:0]   oCOUNT
);

    localparam int unsigned CNT_W = P_DEPTH_N + 1;

    function automatic logic [2:0] calcFault(
        input logic                pageFault,
        input logic [5:0]          flags,
        input logic                paging,
        input logic                kernel,
        input logic [OPCODE_W-1:0] opcode
    );
        logic [2:0] f;
        logic       privInst;
        f = 3'b000;
        privInst = opcode inside {FAULT_INSTRUCTION_SRTISR, FAULT_INSTRUCTION_SRKPDTR,
                                  FAULT_INSTRUCTION_SRIEIW, FAULT_INSTRUCTION_SRTISW,
                                  FAULT_INSTRUCTION_SRKPDTW, FAULT_INSTRUCTION_SRMMUW,
                                  FAULT_INSTRUCTION_HALT, FAULT_INSTRUCTION_IDTS};
        if (pageFault || (paging && !flags[0])) begin
            f[FAULT_BIT_PAGEFAULT] = 1'b1;
        end else if (paging && !flags[3]) begin
            f[FAULT_BIT_INVALID] = 1'b1;
        end else if (paging && !kernel && (flags[5:4] == 2'b00)) begin
            f[FAULT_BIT_PRIVILEGE] = 1'b1;
        end else if (!kernel && privInst) begin
            f[FAULT_BIT_PRIVILEGE] = 1'b1;
        end
        return f;
    endfunction

    queueState_t          state;
    logic [CNT_W-1:0]     count;
    logic [P_DEPTH_N-1:0] wrPtr;
    logic [P_DEPTH_N-1:0] rdPtr;
    logic                 outValid;
    queueEntry_t          outEntry;
    queueEntry_t          newEntry;
    queueEntry_t          ramHead;

    logic full;
    logic ramEmpty;
    logic wrEn;
    logic consume;
    logic bypass;
    logic ramWrite;
    logic ramRead;
    logic unusedFlags;

    assign unusedFlags = ^iPREVIOUS_MMU_FLAGS[13:6];

    always_comb begin
        newEntry        = '0;
        newEntry.fault  = calcFault(iPREVIOUS_PAGEFAULT, iPREVIOUS_MMU_FLAGS[5:0],
                                    iPREVIOUS_PAGING_ENA, iPREVIOUS_KERNEL_ACCESS,
                                    iPREVIOUS_INST[30:21]);
        newEntry.kernel = iPREVIOUS_KERNEL_ACCESS;
        newEntry.inst   = iPREVIOUS_INST;
        newEntry.pc     = iPREVIOUS_PC;
    end

    // Handshake decode; lock depends only on registered state
    assign full           = (count == CNT_W'(P_DEPTH + 1));
    assign ramEmpty       = ((count - CNT_W'(outValid)) == '0);
    assign oPREVIOUS_LOCK = full || (state == STATE_FENCE);
    assign oPREVIOUS_FETCH_STOP = (count >= CNT_W'(P_STOP_TH)) || (state == STATE_FENCE);
    assign wrEn     = iPREVIOUS_INST_VALID && !oPREVIOUS_LOCK && !iFREE_REFRESH;
    assign consume  = outValid && !iNEXT_LOCK && !iFREE_REFRESH;
    assign bypass   = wrEn && ramEmpty && (!outValid || consume);
    assign ramWrite = wrEn && !bypass;
    assign ramRead  = consume && !ramEmpty;

    fetch_inst_queue_ram #(
        .P_DEPTH   (P_DEPTH),
        .P_DEPTH_N (P_DEPTH_N)
    ) u_ram (
        .iCLOCK   (iCLOCK),
        .iWR_ENA  (ramWrite),
        .iWR_ADDR (wrPtr),
        .iWR_DATA (newEntry),
        .iRD_ADDR (rdPtr),
        .oRD_DATA (ramHead)
    );

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state    <= STATE_RUN;
            count    <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            outValid <= 1'b0;
            outEntry <= '0;
        end else if (iFREE_REFRESH) begin
            state    <= STATE_RUN;
            count    <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            outValid <= 1'b0;
        end else begin
            count <= count + CNT_W'(wrEn) - CNT_W'(consume);
            if (ramWrite) begin
                wrPtr <= wrPtr + P_DEPTH_N'(1);
            end
            if (ramRead) begin
                rdPtr <= rdPtr + P_DEPTH_N'(1);
            end
            // Output stage: reload on consume, fill from bypass when idle
            if (consume) begin
                if (!ramEmpty) begin
                    outEntry <= ramHead;
                end else if (bypass) begin
                    outEntry <= newEntry;
                end else begin
                    outValid <= 1'b0;
                end
            end else if (bypass) begin
                outValid <= 1'b1;
                outEntry <= newEntry;
            end
            if ((state == STATE_RUN) && wrEn && (newEntry.fault != 3'b000)
                    && (P_FAULT_FENCE != 0)) begin
                state <= STATE_FENCE;
            end
        end
    end

    assign oNEXT_INST_VALID            = outValid;
    assign oNEXT_FAULT_PAGEFAULT       = outEntry.fault[FAULT_BIT_PAGEFAULT];
    assign oNEXT_FAULT_PRIVILEGE_ERROR = outEntry.fault[FAULT_BIT_PRIVILEGE];
    assign oNEXT_FAULT_INVALID_INST    = outEntry.fault[FAULT_BIT_INVALID];
    assign oNEXT_INST                  = outEntry.inst;
    assign oNEXT_PC                    = outEntry.pc;
    assign oNEXT_KERNEL                = outEntry.kernel;
    assign oCOUNT                      = count;

endmodule
